gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises one combinational N_IN-input logic gate instance (e.g. the team's 2-input AND component).
- Drives every input vector in ascending order and waits a programmable settle time per vector.
- Captures the gate output for each vector, compares it against an expected truth table, and reports pass/fail plus per-vector results.
- Sits between a lab top-level (start button / bench) and the gate under test, replacing hand-written stimulus blocks.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..6.
- SETTLE, 1, cycles each vector is held before capture; legal range 1..15.
- EXPECT, 4'b1000, expected truth table of width 2**N_IN; bit i is the expected output for input vector i (default = 2-input AND).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- vec_out  output  N_IN  stimulus to the gate inputs; vec_out[0] drives the LSB operand.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  1 when the last completed sweep had no mismatches.
- result  output  2**N_IN  captured truth table; bit i = gate_out sampled for vector i.
- mismatch  output  2**N_IN  bit i = result[i] XOR EXPECT[i].

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-low (`rst_n`). All outputs are registered.
- Reset (rst_n=0, at any time including mid-sweep): state=IDLE; vec_out=0, busy=0, done=0, pass=0, result=0, mismatch=0, internal index and settle counter = 0. Takes effect immediately, without waiting for clk.
- FSM states: IDLE, WAIT, CAPTURE, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: clear result, mismatch and pass; set index=0, vec_out=0, counter=SETTLE-1, busy=1; go to WAIT.
  - start=0: remain in IDLE; result, mismatch and pass hold their values.
- WAIT:
  - vec_out holds the current index.
  - counter>0: decrement and stay in WAIT.
  - counter==0: go to CAPTURE.
  - Each vector therefore spends SETTLE cycles in WAIT.
- CAPTURE (one cycle):
  - result[index] <= gate_out; mismatch[index] <= gate_out ^ EXPECT[index].
  - If index == 2**N_IN-1: go to DONE with busy=0.
  - Otherwise: index and vec_out increment, counter reloads to SETTLE-1, go to WAIT.
- DONE (one cycle):
  - done=1; pass <= ~|mismatch (including the bit written in the final CAPTURE).
  - vec_out returns to 0; next state is IDLE.
- Latency:
  - busy rises on the edge that samples start and stays high for exactly 2**N_IN*(SETTLE+1) cycles.
  - done is high in the cycle immediately after busy falls.
  - Example: N_IN=2, SETTLE=1 gives busy for 8 cycles and done in cycle 9 after the start edge.
- Index width: N_IN bits. No wrap occurs because the last vector is detected by compare, not by overflow.
- start while busy or in DONE: ignored, no restart. A start held high continuously re-triggers only after returning to IDLE.
- abort=1 in WAIT or CAPTURE:
  - Next state is IDLE; busy=0, vec_out=0, no done pulse, pass=0.
  - result and mismatch keep their partial contents.
  - abort has priority over a CAPTURE in the same cycle; that capture is discarded.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins (abort is meaningless in IDLE).
- gate_out is only sampled in CAPTURE; its value in other states is don't-care.

Test Plan:
- Gate = 2-input AND, defaults; pulse start -> vec_out steps 0,1,2,3 each held 2 cycles; busy high 8 cycles; done pulse; result=4'b1000, mismatch=4'b0000, pass=1.
- Gate = 2-input OR, EXPECT=4'b1000 -> result=4'b1110, mismatch=4'b0110, pass=0, done pulse still asserted.
- SETTLE=3, AND gate -> busy high exactly 16 cycles; each vector held 4 cycles; done one cycle after busy falls; pass=1.
- start re-pulsed at cycle 3 of a sweep -> no restart, total busy still 8 cycles; start held high -> second sweep begins only after DONE→IDLE.
- abort at vector 2 (during WAIT) -> next cycle busy=0, vec_out=0, done never pulses, pass=0, result[1:0] captured and result[3:2]=0.
- rst_n low mid-sweep (between edges) -> all outputs zero immediately; after release, state is IDLE and a new start runs a full clean sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Walks every input vector of an N_IN-input gate, holds each for SETTLE cycles,
// captures the gate output and compares it against the EXPECT truth table.
module gate_sweep_ctrl #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   gate_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   result,
    output logic [(1<<N_IN)-1:0]   mismatch
);

    localparam int              NV       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N_IN-1:0] r_idx;
    logic [3:0]      r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [NV-1:0]   r_result;
    logic [NV-1:0]   r_mismatch;
    logic            w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (abort)             w_next = S_IDLE;
                else if (r_cnt == 4'd0) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_WAIT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The index doubles as the stimulus register; it is zeroed whenever the sweep ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_result   <= '0;
            r_mismatch <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_result   <= '0;
                        r_mismatch <= '0;
                        r_pass     <= 1'b0;
                        r_idx      <= '0;
                        r_cnt      <= CNT_LOAD;
                        r_busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_busy <= 1'b0;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_pass <= 1'b0;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        r_busy <= 1'b0;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_pass <= 1'b0;
                    end else begin
                        r_result[r_idx]   <= gate_out;
                        r_mismatch[r_idx] <= gate_out ^ EXPECT[r_idx];
                        if (w_last) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                            r_idx  <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= CNT_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_pass <= ~|r_mismatch;
                end
                default: ;
            endcase
        end
    end

    assign vec_out  = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign result   = r_result;
    assign mismatch = r_mismatch;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: two controller instances (SETTLE=1 and SETTLE=3) driving modelled AND/OR gates.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0, or_a = 1'b0;
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [1:0] vec_a, vec_b;
    logic       gate_a, gate_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [3:0] result_a, mismatch_a, result_b, mismatch_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign gate_a = or_a ? (|vec_a) : (&vec_a);
    assign gate_b = &vec_b;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .vec_out(vec_a), .gate_out(gate_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .result(result_a), .mismatch(mismatch_a)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXPECT(4'b1000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .vec_out(vec_b), .gate_out(gate_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .result(result_b), .mismatch(mismatch_b)
    );

    // Pulses start on the selected instance and stops in the done cycle (or at the bound).
    task automatic measure(input bit sel, input int hold,
                           output int busy_n, output int done_at, output int vec_err);
        busy_n = 0; done_at = -1; vec_err = 0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (sel ? busy_b : busy_a) begin
                busy_n++;
                if (int'(sel ? vec_b : vec_a) != (c - 1) / hold) vec_err++;
            end
            if (sel ? done_b : done_a) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({busy_a, done_a, pass_a, vec_a, result_a, mismatch_a} !== 13'd0) begin
            bad++;
            $display("FAIL reset_a got=%0h exp=0", {busy_a, done_a, pass_a, vec_a, result_a, mismatch_a});
        end
        total++;
        if ({busy_b, done_b, pass_b, vec_b, result_b, mismatch_b} !== 13'd0) begin
            bad++;
            $display("FAIL reset_b got=%0h exp=0", {busy_b, done_b, pass_b, vec_b, result_b, mismatch_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_and;
        int bn, da, ve;
        or_a = 1'b0;
        measure(1'b0, 2, bn, da, ve);
        total++; if (bn !== 8)  begin bad++; $display("FAIL and_busy got=%0d exp=8", bn); end
        total++; if (da !== 9)  begin bad++; $display("FAIL and_done_at got=%0d exp=9", da); end
        total++; if (ve !== 0)  begin bad++; $display("FAIL and_vec_err got=%0d exp=0", ve); end
        total++; if (result_a !== 4'b1000) begin bad++; $display("FAIL and_result got=%b exp=1000", result_a); end
        total++; if (mismatch_a !== 4'b0000) begin bad++; $display("FAIL and_mismatch got=%b exp=0000", mismatch_a); end
        @(negedge clk);
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL and_pass got=%b exp=1", pass_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL and_done_width got=%b exp=0", done_a); end
        total++; if (vec_a !== 2'd0) begin bad++; $display("FAIL and_vec_idle got=%0d exp=0", vec_a); end
    endtask

    task automatic test_or;
        int bn, da, ve;
        or_a = 1'b1;
        measure(1'b0, 2, bn, da, ve);
        total++; if (da !== 9) begin bad++; $display("FAIL or_done_at got=%0d exp=9", da); end
        total++; if (result_a !== 4'b1110) begin bad++; $display("FAIL or_result got=%b exp=1110", result_a); end
        total++; if (mismatch_a !== 4'b0110) begin bad++; $display("FAIL or_mismatch got=%b exp=0110", mismatch_a); end
        @(negedge clk);
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL or_pass got=%b exp=0", pass_a); end
        or_a = 1'b0;
    endtask

    task automatic test_settle3;
        int bn, da, ve;
        measure(1'b1, 4, bn, da, ve);
        total++; if (bn !== 16) begin bad++; $display("FAIL s3_busy got=%0d exp=16", bn); end
        total++; if (da !== 17) begin bad++; $display("FAIL s3_done_at got=%0d exp=17", da); end
        total++; if (ve !== 0)  begin bad++; $display("FAIL s3_vec_err got=%0d exp=0", ve); end
        total++; if (result_b !== 4'b1000) begin bad++; $display("FAIL s3_result got=%b exp=1000", result_b); end
        @(negedge clk);
        total++; if (pass_b !== 1'b1) begin bad++; $display("FAIL s3_pass got=%b exp=1", pass_b); end
    endtask

    task automatic test_back_to_back;
        int bn = 0, da = -1;
        logic d9 = 1'b0, b10 = 1'b1, b11 = 1'b0, second = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            start_a = (c == 0 || c == 3);
            @(negedge clk);
            if (busy_a) bn++;
            if (done_a && da < 0) da = c + 1;
        end
        start_a = 1'b0;
        total++; if (bn !== 8) begin bad++; $display("FAIL repulse_busy got=%0d exp=8", bn); end
        total++; if (da !== 9) begin bad++; $display("FAIL repulse_done_at got=%0d exp=9", da); end
        start_a = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 9)  d9  = done_a;
            if (c == 10) b10 = busy_a;
            if (c == 11) b11 = busy_a;
        end
        start_a = 1'b0;
        total++; if (d9 !== 1'b1)  begin bad++; $display("FAIL held_done9 got=%b exp=1", d9); end
        total++; if (b10 !== 1'b0) begin bad++; $display("FAIL held_idle_gap got=%b exp=0", b10); end
        total++; if (b11 !== 1'b1) begin bad++; $display("FAIL held_restart got=%b exp=1", b11); end
        for (int c = 0; c < 20 && !second; c++) begin
            @(negedge clk);
            if (done_a) second = 1'b1;
        end
        total++; if (second !== 1'b1) begin bad++; $display("FAIL held_second_done got=%b exp=1", second); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int dn = 0;
        or_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (vec_a !== 2'd2 || busy_a !== 1'b1) begin
            bad++; $display("FAIL abort_pre got=vec%0d/busy%b exp=vec2/busy1", vec_a, busy_a);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        total++; if (vec_a !== 2'd0) begin bad++; $display("FAIL abort_vec got=%0d exp=0", vec_a); end
        total++; if (result_a !== 4'b0010) begin bad++; $display("FAIL abort_result got=%b exp=0010", result_a); end
        total++; if (mismatch_a !== 4'b0010) begin bad++; $display("FAIL abort_mismatch got=%b exp=0010", mismatch_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL abort_pass got=%b exp=0", pass_a); end
        for (int c = 0; c < 12; c++) begin
            if (done_a) dn++;
            @(negedge clk);
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
    endtask

    task automatic test_reset_mid;
        int bn, da, ve;
        or_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy_a, done_a, pass_a, vec_a, result_a, mismatch_a} !== 13'd0) begin
            bad++;
            $display("FAIL rstmid_outputs got=%0h exp=0", {busy_a, done_a, pass_a, vec_a, result_a, mismatch_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        or_a = 1'b0;
        measure(1'b0, 2, bn, da, ve);
        total++; if (bn !== 8 || da !== 9) begin
            bad++; $display("FAIL rstmid_sweep got=busy%0d/done%0d exp=busy8/done9", bn, da);
        end
        total++; if (result_a !== 4'b1000) begin bad++; $display("FAIL rstmid_result got=%b exp=1000", result_a); end
        @(negedge clk);
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL rstmid_pass got=%b exp=1", pass_a); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_or();
        test_settle3();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
